wb_slave_regfile: RTL and testbench

- Synthesizable Wishbone classic (B3) slave: a register file of DEPTH words.
- Responder end for the team's Wishbone master BFM; used in the wishbone_bfm bench as the DUT-side target.
- Supports byte-lane writes, programmable wait states, error response on out-of-range addresses and optional retry injection.

---
 rtl/wb_slave_regfile_if.sv | 47 ++++
 rtl/wb_slave_regfile.sv | 227 ++++++++++++++++++++++
 tb/tb_wb_slave_regfile.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_regfile_if.sv
// -----------------------------------------------------------------------------
// wb_slave_regfile_if
// Wishbone classic (B3) bus bundle between a master and the register-file
// slave. Signal names keep the slave-side view (_i = into the slave,
// _o = out of the slave) so they line up with the slave's documentation.
//
// Parameters:
//   DWIDTH  data width (multiple of 8)
//   AWIDTH  byte address width
//
// Signals:
//   wb_adr_i  byte address            wb_dat_i  write data
//   wb_sel_i  byte-lane enables       wb_dat_o  read data
//   wb_cyc_i  bus cycle active        wb_stb_i  transfer request
//   wb_we_i   1 = write, 0 = read
//   wb_ack_o  normal termination      wb_err_o  error termination
//   wb_rty_o  retry termination
//
// Modports: master (drives requests), slave (drives data/terminations).
// -----------------------------------------------------------------------------
interface wb_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) ();

    logic [AWIDTH-1:0]   wb_adr_i;
    logic [DWIDTH-1:0]   wb_dat_i;
    logic [DWIDTH-1:0]   wb_dat_o;
    logic [DWIDTH/8-1:0] wb_sel_i;
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic                wb_we_i;
    logic                wb_ack_o;
    logic                wb_err_o;
    logic                wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/wb_slave_regfile.sv
// -----------------------------------------------------------------------------
// wb_slave_regfile
// Wishbone classic (B3) slave holding DEPTH registers of DWIDTH bits with
// byte-lane writes, WAIT_STATES programmable wait cycles, an error response
// for addresses beyond the register file and optional retry injection.
//
// Optional feature macro: WB_SLV_RETRY_EN
//   defined   : accesses to word RETRY_ADDR are answered with RETRY_NUM retry
//               terminations before one is acked (3-bit retry counter).
//   undefined : wb_rty_o is tied low, no retry counter exists.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   wb   wb_if.slave bundle (adr/dat/sel/cyc/stb/we in, dat/ack/err/rty out)
//
// Timing: a request sampled at edge N gives a termination that is high
// between edges N+1+WAIT_STATES and N+2+WAIT_STATES. All outputs are
// registered; the termination registers load while the FSM is in RESP.
// -----------------------------------------------------------------------------
module wb_slave_regfile #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int RETRY_ADDR  = 0,
    parameter int RETRY_NUM   = 2
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wb
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam int         SEL_W   = DWIDTH / 8;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [AWIDTH-1:0]   adr_q;
    logic                we_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DWIDTH-1:0]   dat_q;
    logic [DWIDTH-1:0]   regs_q [DEPTH];
    logic                ack_q, err_q;
    logic                ack_d, err_d;
    logic [DWIDTH-1:0]   dat_o_q, dat_o_d;
    logic                req_s, term_busy_s, oor_s, wr_en_s;
    logic [IDX_W-1:0]    idx_s;
    logic                unused_s;

`ifdef WB_SLV_RETRY_EN
    localparam logic [2:0] RETRY_LIM = 3'(RETRY_NUM);
    logic                rty_q, rty_d;
    logic [2:0]          rty_cnt_q, rty_cnt_d;
    logic                retry_hit_s;

    assign retry_hit_s = (idx_s == IDX_W'(RETRY_ADDR));
    assign term_busy_s = ack_q | err_q | rty_q;
    assign wb.wb_rty_o = rty_q;
    assign unused_s    = ^adr_q[1:0];
`else
    assign term_busy_s = ack_q | err_q;
    assign wb.wb_rty_o = 1'b0;
    assign unused_s    = ^{adr_q[1:0], 1'(RETRY_ADDR), 1'(RETRY_NUM)};
`endif

    // While a termination is still visible the master has not yet removed
    // its strobe, so a new request is not accepted in that cycle.
    assign req_s   = (state_q == ST_IDLE) & wb.wb_cyc_i & wb.wb_stb_i & ~term_busy_s;
    assign idx_s   = adr_q[IDX_W+1:2];
    assign oor_s   = |adr_q[AWIDTH-1:IDX_W+2];
    assign wr_en_s = ack_d & we_q;

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_o_q;

    // State and wait-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept, count down wait states, abort on cyc loss
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_LD != 4'd0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    // <= also recovers from a corrupted zero count
                    state_d = (cnt_q <= 4'd1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode: pick exactly one termination while in RESP
    always_comb begin
        ack_d = 1'b0;
        err_d = 1'b0;
`ifdef WB_SLV_RETRY_EN
        rty_d     = 1'b0;
        rty_cnt_d = rty_cnt_q;
`endif
        if (state_q == ST_RESP) begin
            if (oor_s) begin
                err_d = 1'b1;
`ifdef WB_SLV_RETRY_EN
            end else if (retry_hit_s) begin
                if (rty_cnt_q == RETRY_LIM) begin
                    ack_d     = 1'b1;
                    rty_cnt_d = 3'd0;
                end else begin
                    rty_d     = 1'b1;
                    rty_cnt_d = rty_cnt_q + 3'd1;
                end
`endif
            end else begin
                ack_d = 1'b1;
            end
        end else begin
            ack_d = 1'b0;
        end
    end

    // Read-data next value: load on read ack, clear on err, otherwise hold
    always_comb begin
        dat_o_d = dat_o_q;
        if (ack_d && !we_q) begin
            dat_o_d = regs_q[idx_s];
        end else if (err_d) begin
            dat_o_d = '0;
        end else begin
            dat_o_d = dat_o_q;
        end
    end

    // Request capture: address, direction, lanes and data frozen at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
        end else if (req_s) begin
            adr_q <= wb.wb_adr_i;
            we_q  <= wb.wb_we_i;
            sel_q <= wb.wb_sel_i;
            dat_q <= wb.wb_dat_i;
        end
    end

    // Register file: byte-lane merge on an acked write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (sel_q[k]) begin
                    regs_q[idx_s][8*k +: 8] <= dat_q[8*k +: 8];
                end
            end
        end
    end

    // Registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_o_q <= dat_o_d;
        end
    end

`ifdef WB_SLV_RETRY_EN
    // Retry termination and retry counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rty_q     <= 1'b0;
            rty_cnt_q <= 3'd0;
        end else begin
            rty_q     <= rty_d;
            rty_cnt_q <= rty_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_wb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_regfile
// Self-checking bench for wb_slave_regfile (WAIT_STATES = 3). A behavioural
// model (word array + byte masks) predicts every termination and the read
// data; a compare process checks all outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_wb_slave_regfile;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int WS    = 3;
    localparam int RA    = 3;
    localparam int RN    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_if #(.DWIDTH(DW), .AWIDTH(AW)) wb ();

    wb_slave_regfile #(
        .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH),
        .WAIT_STATES(WS), .RETRY_ADDR(RA), .RETRY_NUM(RN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb (wb)
    );

    int n_total = 0;
    int n_pass  = 0;

    // expected outputs for the current cycle
    logic        exp_ack = 1'b0, exp_err = 1'b0, exp_rty = 1'b0;
    logic [31:0] exp_dat = 32'h0;
    logic        chk_en  = 1'b0;

    // behavioural model state
    logic [31:0] mem [DEPTH];
    int          m_rty_cnt;
    logic        n_ack, n_err, n_rty;
    logic [31:0] n_dat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        m_rty_cnt = 0;
    endfunction

    // Predict the outcome of one access and update the model memory.
    function automatic void model_access(input logic [31:0] adr, input logic we,
                                         input logic [3:0] sel, input logic [31:0] dat);
        int          idx;
        logic [31:0] mask;
        logic        retry;
        n_ack = 1'b0; n_err = 1'b0; n_rty = 1'b0; n_dat = exp_dat;
        retry = 1'b0;
        if (adr >= 32'(DEPTH * 4)) begin
            n_err = 1'b1;
            n_dat = 32'h0;
        end else begin
            idx = int'(adr / 4);
`ifdef WB_SLV_RETRY_EN
            if (idx == RA) begin
                if (m_rty_cnt < RN) begin
                    retry = 1'b1;
                    m_rty_cnt++;
                end else begin
                    m_rty_cnt = 0;
                end
            end
`endif
            if (retry) begin
                n_rty = 1'b1;
            end else begin
                n_ack = 1'b1;
                if (we) begin
                    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                    mem[idx] = (mem[idx] & ~mask) | (dat & mask);
                end else begin
                    n_dat = mem[idx];
                end
            end
        end
    endfunction

    // Per-cycle comparison of all slave outputs against the expectation
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ack", 32'(wb.wb_ack_o), 32'(exp_ack));
            check("err", 32'(wb.wb_err_o), 32'(exp_err));
            check("rty", 32'(wb.wb_rty_o), 32'(exp_rty));
            check("dat_o", wb.wb_dat_o, exp_dat);
        end
    end

    task automatic drive_req(input logic [31:0] adr, input logic we,
                             input logic [3:0] sel, input logic [31:0] dat);
        wb.wb_adr_i = adr; wb.wb_we_i = we; wb.wb_sel_i = sel; wb.wb_dat_i = dat;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    endtask

    task automatic release_bus();
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    endtask

    // One transfer; abort_k >= 0 drops cyc k cycles after the sample edge.
    // Entered and left #1 after a rising edge.
    task automatic do_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int abort_k);
        drive_req(adr, we, sel, dat);
        @(posedge clk);                         // sample edge N
        if (abort_k >= 0) begin
            repeat (abort_k) @(posedge clk);
            #1 release_bus();
            @(posedge clk); #1;
        end else begin
            model_access(adr, we, sel, dat);
            repeat (WS + 1) @(posedge clk);     // edge N+1+WS
            #1;
            exp_ack = n_ack; exp_err = n_err; exp_rty = n_rty; exp_dat = n_dat;
            @(posedge clk); #1;                 // edge N+2+WS
            exp_ack = 1'b0; exp_err = 1'b0; exp_rty = 1'b0;
            release_bus();
        end
    endtask

    // Reset asserted while the slave is counting wait states
    task automatic do_reset_mid(input logic [31:0] adr, input logic [31:0] dat);
        drive_req(adr, 1'b1, 4'hF, dat);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_ack", 32'(wb.wb_ack_o), 32'h0);
        check("rst_err", 32'(wb.wb_err_o), 32'h0);
        check("rst_rty", 32'(wb.wb_rty_o), 32'h0);
        check("rst_dat", wb.wb_dat_o, 32'h0);
        model_reset();
        exp_ack = 1'b0; exp_err = 1'b0; exp_rty = 1'b0; exp_dat = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        release_bus();
    endtask

    initial begin
        logic [31:0] adr, dat;
        int          r;
        rst = 1'b1;
        wb.wb_adr_i = 32'h0; wb.wb_dat_i = 32'h0; wb.wb_sel_i = 4'h0;
        wb.wb_we_i = 1'b0; release_bus();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(wb.wb_ack_o), 32'h0);
        check("reset_err", 32'(wb.wb_err_o), 32'h0);
        check("reset_rty", 32'(wb.wb_rty_o), 32'h0);
        check("reset_dat", wb.wb_dat_o, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // read after reset returns zero
        do_xfer(32'h0, 1'b0, 4'hF, 32'h0, -1);
        check("rd0_after_reset", wb.wb_dat_o, 32'h0);

        // write / readback
        do_xfer(32'h8, 1'b1, 4'hF, 32'hDEADBEEF, -1);
        do_xfer(32'h8, 1'b0, 4'hF, 32'h0, -1);
        check("rd_deadbeef", wb.wb_dat_o, 32'hDEADBEEF);
        check("model_deadbeef", exp_dat, 32'hDEADBEEF);

        // byte lanes 0 and 2
        do_xfer(32'h8, 1'b1, 4'h5, 32'h11223344, -1);
        do_xfer(32'hB, 1'b0, 4'hF, 32'h0, -1);   // low address bits ignored
        check("rd_bytelane", wb.wb_dat_o, 32'hDE22BE44);
        check("model_bytelane", exp_dat, 32'hDE22BE44);

        // sel = 0 write leaves the register alone
        do_xfer(32'h8, 1'b1, 4'h0, 32'h0BAD0BAD, -1);
        do_xfer(32'h8, 1'b0, 4'hF, 32'h0, -1);
        check("rd_sel0", wb.wb_dat_o, 32'hDE22BE44);

        // out of range: err, dat_o cleared, nothing written
        do_xfer(32'h40, 1'b1, 4'hF, 32'hFFFFFFFF, -1);
        check("err_dat_zero", wb.wb_dat_o, 32'h0);
        do_xfer(32'h0, 1'b0, 4'hF, 32'h0, -1);
        check("rd0_after_err", wb.wb_dat_o, 32'h0);

        // aborted write leaves the old value
        do_xfer(32'h4, 1'b1, 4'hF, 32'h12345678, -1);
        do_xfer(32'h4, 1'b1, 4'hF, 32'hCAFEF00D, 0);
        do_xfer(32'h4, 1'b0, 4'hF, 32'h0, -1);
        check("rd_after_abort", wb.wb_dat_o, 32'h12345678);

        // reset during wait states clears everything
        do_reset_mid(32'h8, 32'h55555555);
        do_xfer(32'h8, 1'b0, 4'hF, 32'h0, -1);
        check("rd_after_rst", wb.wb_dat_o, 32'h0);
        do_xfer(32'h4, 1'b0, 4'hF, 32'h0, -1);
        check("rd4_after_rst", wb.wb_dat_o, 32'h0);

`ifdef WB_SLV_RETRY_EN
        // two retries then an ack on word 3; a fourth access retries again
        for (int i = 0; i < 3; i++) do_xfer(32'hC, 1'b1, 4'hF, 32'hA5, -1);
        check("model_retry_mem", mem[3], 32'hA5);
        do_xfer(32'hC, 1'b0, 4'hF, 32'h0, -1);
`endif

        // randomized traffic
        for (int t = 0; t < 250; t++) begin
            r   = int'($urandom_range(0, 99));
            dat = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                adr = $urandom;
                if (adr < 32'(DEPTH * 4)) adr = adr | 32'h100;
            end else begin
                adr = 32'($urandom_range(0, DEPTH * 4 - 1));
            end
            if (r < 3) begin
                do_reset_mid(adr, dat);
            end else if (r < 12) begin
                do_xfer(adr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), dat,
                        int'($urandom_range(0, WS - 1)));
            end else begin
                do_xfer(adr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), dat, -1);
            end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
